// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and FSM encoding for the CNN datapath blocks
package cnn_pkg;
  localparam int MEM_DEPTH = 128;
  localparam int MEM_ADR_W = 7;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_X = 2'd1,
    RD_W = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: registered signed multiply-accumulate with synchronous clear
module mac_unit #(
  parameter int DATA_W = 32,
  parameter int ACC_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]  acc_o
);
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0] acc_d, acc_q;
  // operands are sign-extended first so the truncated product is the signed result
  always_comb begin
    prod = {{DATA_W{a_i[DATA_W-1]}}, a_i} * {{DATA_W{b_i[DATA_W-1]}}, b_i};
    acc_d = clr_i ? '0 : en_i ? acc_q + ACC_W'($signed(prod)) : acc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  end
  assign acc_o = acc_q;
endmodule

// File: rtl/conv_mac_reader.sv
// conv_mac_reader: walks an input window and a filter through one read port
// and returns their signed dot product over a valid/ready handshake
module conv_mac_reader
  import cnn_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADR_W = MEM_ADR_W,
  parameter int LEN_W = 8,
  parameter int ACC_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADR_W-1:0]  x_base,
  input  logic [ADR_W-1:0]  w_base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic [ADR_W-1:0]  mem_adr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);
  state_t state_q, state_d;
  logic [ADR_W-1:0] x_ptr_q, x_ptr_d, w_ptr_q, w_ptr_d, adr_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic go, mac_clr, mac_en;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (start ? (len != '0 ? RD_X : DONE) : IDLE)
            : state_q == RD_X ? RD_W
            : state_q == RD_W ? (cnt_q == LEN_W'(1) ? DONE : RD_X)
            : (result_ready ? IDLE : DONE);
  end
  // mem_adr holds its last driven value outside the read states
  always_comb begin
    go = state_q == IDLE && start;
    busy = state_q != IDLE;
    mem_re = state_q == RD_X || state_q == RD_W;
    mem_adr = state_q == RD_X ? x_ptr_q : state_q == RD_W ? w_ptr_q : adr_q;
    result_valid = state_q == DONE;
    mac_clr = go;
    mac_en = state_q == RD_W;
  end
  always_comb begin
    x_ptr_d = go ? x_base : state_q == RD_X ? x_ptr_q + ADR_W'(1) : x_ptr_q;
    w_ptr_d = go ? w_base : state_q == RD_W ? w_ptr_q + ADR_W'(1) : w_ptr_q;
    cnt_d = go ? len : state_q == RD_W ? cnt_q - LEN_W'(1) : cnt_q;
    x_d = state_q == RD_X ? mem_data : x_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_ptr_q <= '0;
      w_ptr_q <= '0;
      cnt_q <= '0;
      x_q <= '0;
      adr_q <= '0;
    end else begin
      x_ptr_q <= x_ptr_d;
      w_ptr_q <= w_ptr_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      adr_q <= mem_adr;
    end
  end
  mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk),
    .rst(rst),
    .clr_i(mac_clr),
    .en_i(mac_en),
    .a_i(x_q),
    .b_i(mem_data),
    .acc_o(result)
  );
endmodule

// File: tb/tb_conv_mac_reader.sv
// tb_conv_mac_reader: directed scoreboard bench for conv_mac_reader
module tb_conv_mac_reader;
  logic clk = 1'b0;
  logic rst, start, result_ready;
  logic [6:0] x_base, w_base, mem_adr;
  logic [7:0] len;
  logic busy, mem_re, result_valid;
  logic [31:0] mem_data;
  logic [63:0] result;
  logic [31:0] mem [128];
  int tests = 0;
  int fails = 0;
  logic [6:0] exp_adr[$];
  logic [63:0] exp_res[$];

  always #5 clk = ~clk;
  assign mem_data = mem[mem_adr];

  conv_mac_reader dut (
    .clk(clk), .rst(rst), .start(start), .x_base(x_base), .w_base(w_base),
    .len(len), .busy(busy), .mem_adr(mem_adr), .mem_re(mem_re),
    .mem_data(mem_data), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every read and every accepted result is checked against the queues
  always @(negedge clk) begin
    if (mem_re) begin
      if (exp_adr.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_read: got adr %0d expected no read", mem_adr);
      end else chk("rd_adr", {57'd0, mem_adr}, {57'd0, exp_adr.pop_front()});
    end
    if (result_valid && result_ready) begin
      if (exp_res.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %h expected none", result);
      end else chk("result", result, exp_res.pop_front());
    end
  end

  task automatic run(input logic [6:0] xb, input logic [6:0] wb, input logic [7:0] l,
                     input logic [63:0] exp, input int poke);
    logic [6:0] a;
    int k;
    for (int i = 0; i < int'(l); i++) begin
      a = xb + 7'(i);
      exp_adr.push_back(a);
      a = wb + 7'(i);
      exp_adr.push_back(a);
    end
    exp_res.push_back(exp);
    @(posedge clk); #1;
    start = 1; x_base = xb; w_base = wb; len = l;
    @(posedge clk); #1;
    start = 0;
    k = 1;
    while (!result_valid && k < 600) begin
      if (k == poke) begin
        start = 1; x_base = 7'd50; w_base = 7'd60; len = 8'd1;
      end else start = 0;
      @(posedge clk); #1;
      k++;
    end
    start = 0;
    chk("latency", 64'(k), 64'(2 * int'(l) + 1));
    @(posedge clk); #1;
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    rst = 1; start = 0; result_ready = 1; x_base = 0; w_base = 0; len = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_re", {63'd0, mem_re}, 64'd0);
    chk("rst_adr", {57'd0, mem_adr}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_valid", {63'd0, result_valid}, 64'd0);
    rst = 0;
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[10] = 4; mem[11] = 5; mem[12] = 6;
    run(7'd0, 7'd10, 8'd3, 64'd32, 0);
    run(7'd0, 7'd10, 8'd3, 64'd32, 2);
    mem[0] = 32'hFFFFFFFE; mem[1] = 32'h7FFFFFFF;
    run(7'd1, 7'd1, 8'd1, 64'h3FFFFFFF00000001, 0);
    run(7'd0, 7'd1, 8'd1, 64'hFFFFFFFF00000002, 0);
    mem[126] = 1; mem[127] = 2; mem[0] = 3;
    run(7'd126, 7'd126, 8'd3, 64'd14, 0);
    // len=0 under back-pressure, then handshake with a simultaneous start
    result_ready = 0;
    exp_res.push_back(64'd0);
    @(posedge clk); #1;
    start = 1; len = 0; x_base = 7'd5; w_base = 7'd5;
    @(posedge clk); #1;
    start = 0;
    chk("len0_valid", {63'd0, result_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'd0, result_valid}, 64'd1);
      chk("bp_result", result, 64'd0);
      chk("bp_busy", {63'd0, busy}, 64'd1);
    end
    result_ready = 1; start = 1; len = 8'd2;
    @(posedge clk); #1;
    start = 0;
    chk("hs_busy", {63'd0, busy}, 64'd0);
    chk("hs_valid", {63'd0, result_valid}, 64'd0);
    @(posedge clk); #1;
    chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
    // reset in the 4th cycle of a long run
    mem[20] = 32'd3; mem[21] = 32'hFFFFFFFB; mem[30] = 32'd9; mem[31] = 32'd11;
    exp_adr.push_back(7'd20); exp_adr.push_back(7'd30);
    exp_adr.push_back(7'd21); exp_adr.push_back(7'd31);
    @(posedge clk); #1;
    start = 1; x_base = 7'd20; w_base = 7'd30; len = 8'd10;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_valid", {63'd0, result_valid}, 64'd0);
    chk("abort_re", {63'd0, mem_re}, 64'd0);
    chk("abort_result", result, 64'd0);
    run(7'd20, 7'd21, 8'd1, 64'hFFFFFFFFFFFFFFF1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("adr_queue_empty", 64'(exp_adr.size()), 64'd0);
    chk("res_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end
endmodule
